// File: rtl/pc_gen_pkg.sv
// Shared codes for the program-counter generator:
// next-PC selects and FSM states.
package pc_gen_pkg;

    localparam int PC_SEL_W = 3;

    typedef enum logic [PC_SEL_W-1:0] {
        PC_PLUS_STEP = 3'd0,
        PC_JAL       = 3'd1,
        PC_JALR      = 3'd2,
        PC_BRANCH    = 3'd3,
        PC_TRAP      = 3'd4,
        PC_MRET      = 3'd5,
        PC_RET       = 3'd6,
        PC_HOLD      = 3'd7
    } pc_sel_e;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

endpackage

// File: rtl/pc_gen_if.sv
// Control/fetch bundle around the PC generator.
// slave = pc_gen side, master = control/fetch side.
interface pc_gen_if #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic [2:0]      pc_sel;
    logic [XLEN-1:0] jal;
    logic [XLEN-1:0] jalr;
    logic [XLEN-1:0] branch;
    logic [XLEN-1:0] trap_pc;
    logic            link;
    logic            halt_req;
    logic            pc_ready;
    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic [XLEN-1:0] epc;
    logic [CW-1:0]   ras_count;
    logic            ras_miss;
    logic            halted;

    modport slave (
        input  pc_sel, jal, jalr, branch, trap_pc,
        input  link, halt_req, pc_ready,
        output pc, pc_valid, epc, ras_count,
        output ras_miss, halted
    );

    modport master (
        output pc_sel, jal, jalr, branch, trap_pc,
        output link, halt_req, pc_ready,
        input  pc, pc_valid, epc, ras_count,
        input  ras_miss, halted
    );

endinterface

// File: rtl/pc_gen_ras.sv
// Return-address stack: circular buffer whose
// oldest entry is overwritten when a push hits a full stack.
module pc_ras #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           top_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_pop;
    logic             do_push;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;
    assign top_o   = mem_q[ptr_q - PW'(1)];

    // A pop always wins over a simultaneous push.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && !pop_i;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_pop) begin
            ptr_q <= ptr_q - PW'(1);
            cnt_q <= cnt_q - CW'(1);
        end else if (do_push) begin
            mem_q[ptr_q] <= data_i;
            ptr_q        <= ptr_q + PW'(1);
            if (!full_o) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN/HALT control,
// next-PC select, trap EPC and return-address stack.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              STEP      = 1,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(16),
    parameter int              RAS_DEPTH = 4
) (
    input  logic    clock,
    input  logic    reset,
    pc_gen_if.slave bus
);
    localparam int              CW     = $clog2(RAS_DEPTH) + 1;
    localparam logic [XLEN-1:0] STEP_W = XLEN'(STEP);

    pc_state_e       state_q;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            valid_q, halted_q;
    logic            miss_q, miss_d;
    logic [XLEN-1:0] pc_plus;
    logic            fire, upd;
    pc_sel_e         sel;

    logic            push, pop;
    logic [XLEN-1:0] ras_top;
    logic [CW-1:0]   ras_cnt;
    logic            ras_empty, ras_full;

    assign sel     = pc_sel_e'(bus.pc_sel);
    assign pc_plus = pc_q + STEP_W;
    assign fire    = valid_q && bus.pc_ready;
    // A halt request discards this cycle's redirect.
    assign upd     = (state_q == RUN) && !bus.halt_req;

    always_comb begin
        pc_d   = pc_q;
        epc_d  = epc_q;
        miss_d = 1'b0;
        push   = 1'b0;
        pop    = 1'b0;
        if (upd) begin
            unique case (sel)
                PC_PLUS_STEP: if (fire) pc_d = pc_plus;
                PC_JAL: begin
                    pc_d = bus.jal;
                    push = bus.link;
                end
                PC_JALR: begin
                    pc_d = bus.jalr;
                    push = bus.link;
                end
                PC_BRANCH: pc_d = bus.branch;
                PC_TRAP: begin
                    pc_d  = TRAP_VEC;
                    epc_d = bus.trap_pc;
                end
                PC_MRET: pc_d = epc_q;
                PC_RET: begin
                    if (!ras_empty) begin
                        pc_d = ras_top;
                        pop  = 1'b1;
                    end else begin
                        pc_d   = bus.jalr;
                        miss_d = 1'b1;
                    end
                end
                PC_HOLD: pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= BOOT;
            pc_q     <= RESET_VEC;
            epc_q    <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            epc_q  <= epc_d;
            miss_q <= miss_d;
            unique case (state_q)
                BOOT: begin
                    state_q <= RUN;
                    valid_q <= 1'b1;
                end
                RUN: if (bus.halt_req) begin
                    state_q  <= HALT;
                    valid_q  <= 1'b0;
                    halted_q <= 1'b1;
                end
                HALT: if (!bus.halt_req) begin
                    state_q  <= RUN;
                    valid_q  <= 1'b1;
                    halted_q <= 1'b0;
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (XLEN)
    ) u_ras (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (pc_plus),
        .top_o   (ras_top),
        .count_o (ras_cnt),
        .empty_o (ras_empty),
        .full_o  (ras_full)
    );

    assign bus.pc        = pc_q;
    assign bus.pc_valid  = valid_q;
    assign bus.epc       = epc_q;
    assign bus.ras_count = ras_cnt;
    assign bus.ras_miss  = miss_q;
    assign bus.halted    = halted_q;

    a_full_count: assert property (
        @(posedge clock) disable iff (!reset)
        ras_full |-> (ras_cnt == CW'(RAS_DEPTH))
    );

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios
// plus randomized traffic against a queue-based model.
module tb_pc_gen;
    import pc_gen_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    pc_gen_if #(.XLEN(32), .RAS_DEPTH(4)) bus ();
    pc_gen_if #(.XLEN(8),  .RAS_DEPTH(4)) b8 ();

    pc_gen #(
        .XLEN(32), .STEP(1), .RESET_VEC(32'h0),
        .TRAP_VEC(32'd16), .RAS_DEPTH(4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    pc_gen #(
        .XLEN(8), .STEP(1), .RESET_VEC(8'h0),
        .TRAP_VEC(8'd16), .RAS_DEPTH(4)
    ) dut8 (
        .clock (clock),
        .reset (reset),
        .bus   (b8)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: 0=BOOT 1=RUN 2=HALT
    int          m_state;
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic        m_miss;
    logic [31:0] m_ras [$];

    task automatic model_reset();
        m_state = 0;
        m_pc    = 32'h0;
        m_epc   = 32'h0;
        m_miss  = 1'b0;
        m_ras.delete();
    endtask

    task automatic model_step();
        logic fire;
        if (!reset) begin
            model_reset();
            return;
        end
        fire   = (m_state == 1) && bus.pc_ready;
        m_miss = 1'b0;
        if (m_state == 0) begin
            m_state = 1;
        end else if (m_state == 2) begin
            if (!bus.halt_req) m_state = 1;
        end else if (bus.halt_req) begin
            m_state = 2;
        end else begin
            case (bus.pc_sel)
                3'd0: if (fire) m_pc = m_pc + 32'd1;
                3'd1, 3'd2: begin
                    if (bus.link) begin
                        m_ras.push_back(m_pc + 32'd1);
                        if (m_ras.size() > 4)
                            void'(m_ras.pop_front());
                    end
                    m_pc = (bus.pc_sel == 3'd1) ? bus.jal : bus.jalr;
                end
                3'd3: m_pc = bus.branch;
                3'd4: begin
                    m_pc  = 32'd16;
                    m_epc = bus.trap_pc;
                end
                3'd5: m_pc = m_epc;
                3'd6: begin
                    if (m_ras.size() > 0) begin
                        m_pc = m_ras.pop_back();
                    end else begin
                        m_pc   = bus.jalr;
                        m_miss = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic idle();
        bus.pc_sel   = PC_HOLD;
        bus.jal      = '0;
        bus.jalr     = '0;
        bus.branch   = '0;
        bus.trap_pc  = '0;
        bus.link     = 1'b0;
        bus.halt_req = 1'b0;
        bus.pc_ready = 1'b0;
        b8.pc_sel    = PC_HOLD;
        b8.jal       = '0;
        b8.jalr      = '0;
        b8.branch    = '0;
        b8.trap_pc   = '0;
        b8.link      = 1'b0;
        b8.halt_req  = 1'b0;
        b8.pc_ready  = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        tick();
        tick();
        n_chk++;
        if (bus.pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_pc got %h want 0", bus.pc);
        end
        n_chk++;
        if (bus.pc_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got %b want 0", bus.pc_valid);
        end
        n_chk++;
        if (bus.epc !== 32'h0 || bus.ras_count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_epc_cnt got %h/%0d want 0/0",
                     bus.epc, bus.ras_count);
        end
        n_chk++;
        if (bus.ras_miss !== 1'b0 || bus.halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags got miss=%b halted=%b want 0/0",
                     bus.ras_miss, bus.halted);
        end
    endtask

    task automatic test_boot_step();
        reset        = 1'b1;
        bus.pc_ready = 1'b1;
        bus.pc_sel   = PC_PLUS_STEP;
        n_chk++;
        if (bus.pc_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL boot_valid got %b want 0", bus.pc_valid);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++;
            if (bus.pc !== 32'(i) || bus.pc_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL step_seq got pc=%h v=%b want %h v=1",
                         bus.pc, bus.pc_valid, 32'(i));
            end
        end
    endtask

    task automatic test_stall();
        bus.pc_sel = PC_JAL;
        bus.jal    = 32'd5;
        tick();
        bus.pc_sel   = PC_PLUS_STEP;
        bus.pc_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (bus.pc !== 32'd5) begin
                n_fail++;
                $display("FAIL stall_hold got %h want 5", bus.pc);
            end
        end
        bus.pc_sel = PC_BRANCH;
        bus.branch = 32'd40;
        tick();
        n_chk++;
        if (bus.pc !== 32'd40) begin
            n_fail++;
            $display("FAIL branch_stalled got %h want 40", bus.pc);
        end
    endtask

    task automatic test_trap();
        bus.pc_sel = PC_JAL;
        bus.jal    = 32'd7;
        tick();
        bus.pc_sel  = PC_TRAP;
        bus.trap_pc = 32'h22;
        tick();
        n_chk++;
        if (bus.pc !== 32'd16 || bus.epc !== 32'h22) begin
            n_fail++;
            $display("FAIL trap got pc=%h epc=%h want 10/22",
                     bus.pc, bus.epc);
        end
        bus.pc_sel  = PC_MRET;
        bus.trap_pc = 32'h0;
        tick();
        n_chk++;
        if (bus.pc !== 32'h22) begin
            n_fail++;
            $display("FAIL mret got %h want 22", bus.pc);
        end
    endtask

    task automatic test_ras();
        logic [31:0] exp;
        bus.pc_sel = PC_JAL;
        bus.jal    = 32'd1;
        tick();
        for (int k = 0; k < 5; k++) begin
            bus.pc_sel = PC_JAL;
            bus.link   = 1'b1;
            bus.jal    = 32'(11 + 10 * k);
            tick();
        end
        bus.link = 1'b0;
        n_chk++;
        if (bus.ras_count !== 3'd4) begin
            n_fail++;
            $display("FAIL ras_full_count got %0d want 4", bus.ras_count);
        end
        for (int k = 0; k < 4; k++) begin
            bus.pc_sel = PC_RET;
            exp = 32'(42 - 10 * k);
            tick();
            n_chk++;
            if (bus.pc !== exp || bus.ras_miss !== 1'b0) begin
                n_fail++;
                $display("FAIL ras_pop got %h miss=%b want %h miss=0",
                         bus.pc, bus.ras_miss, exp);
            end
        end
        bus.jalr = 32'h99;
        tick();
        n_chk++;
        if (bus.pc !== 32'h99 || bus.ras_miss !== 1'b1) begin
            n_fail++;
            $display("FAIL ras_miss got %h miss=%b want 99 miss=1",
                     bus.pc, bus.ras_miss);
        end
        bus.pc_sel = PC_HOLD;
        tick();
        n_chk++;
        if (bus.ras_miss !== 1'b0 || bus.ras_count !== 3'd0) begin
            n_fail++;
            $display("FAIL miss_pulse got miss=%b cnt=%0d want 0/0",
                     bus.ras_miss, bus.ras_count);
        end
    endtask

    task automatic test_halt();
        bus.pc_sel = PC_JAL;
        bus.jal    = 32'd9;
        tick();
        bus.halt_req = 1'b1;
        bus.jal      = 32'd50;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_chk++;
            if (bus.pc !== 32'd9 || bus.pc_valid !== 1'b0 ||
                bus.halted !== 1'b1) begin
                n_fail++;
                $display("FAIL halt got pc=%h v=%b h=%b want 9/0/1",
                         bus.pc, bus.pc_valid, bus.halted);
            end
        end
        bus.halt_req = 1'b0;
        bus.pc_sel   = PC_HOLD;
        tick();
        n_chk++;
        if (bus.pc !== 32'd9 || bus.pc_valid !== 1'b1 ||
            bus.halted !== 1'b0) begin
            n_fail++;
            $display("FAIL resume got pc=%h v=%b h=%b want 9/1/0",
                     bus.pc, bus.pc_valid, bus.halted);
        end
    endtask

    task automatic test_wrap_async();
        bus.pc_sel = PC_JAL;
        bus.jal    = 32'hFFFF_FFFF;
        b8.pc_sel  = PC_JAL;
        b8.jal     = 8'hFF;
        tick();
        bus.pc_sel   = PC_PLUS_STEP;
        bus.pc_ready = 1'b1;
        b8.pc_sel    = PC_PLUS_STEP;
        b8.pc_ready  = 1'b1;
        tick();
        n_chk++;
        if (b8.pc !== 8'h00) begin
            n_fail++;
            $display("FAIL wrap8 got %h want 00", b8.pc);
        end
        n_chk++;
        if (bus.pc !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap32 got %h want 0", bus.pc);
        end
        bus.pc_sel = PC_JAL;
        bus.jal    = 32'h33;
        tick();
        #2 reset = 1'b0;
        #1;
        n_chk++;
        if (bus.pc !== 32'h0 || bus.pc_valid !== 1'b0 ||
            b8.pc !== 8'h0) begin
            n_fail++;
            $display("FAIL async_reset got pc=%h v=%b pc8=%h want 0/0/0",
                     bus.pc, bus.pc_valid, b8.pc);
        end
        idle();
        tick();
    endtask

    task automatic test_random();
        reset = 1'b1;
        for (int i = 0; i < 800; i++) begin
            bus.pc_sel   = 3'($urandom_range(0, 7));
            bus.jal      = $urandom;
            bus.jalr     = $urandom;
            bus.branch   = $urandom;
            bus.trap_pc  = $urandom;
            bus.link     = ($urandom_range(0, 1) == 1);
            bus.pc_ready = ($urandom_range(0, 1) == 1);
            if (bus.halt_req)
                bus.halt_req = ($urandom_range(0, 2) != 0);
            else
                bus.halt_req = ($urandom_range(0, 9) == 0);
            reset = (i != 400);
            tick();
            n_chk++;
            if (bus.pc !== m_pc || bus.epc !== m_epc) begin
                n_fail++;
                $display("FAIL rnd_pc cyc %0d got %h/%h want %h/%h",
                         i, bus.pc, bus.epc, m_pc, m_epc);
            end
            n_chk++;
            if (bus.pc_valid !== (m_state == 1) ||
                bus.halted !== (m_state == 2)) begin
                n_fail++;
                $display("FAIL rnd_state cyc %0d got v=%b h=%b want st=%0d",
                         i, bus.pc_valid, bus.halted, m_state);
            end
            n_chk++;
            if (bus.ras_count !== 3'(m_ras.size()) ||
                bus.ras_miss !== m_miss) begin
                n_fail++;
                $display("FAIL rnd_ras cyc %0d got %0d/%b want %0d/%b",
                         i, bus.ras_count, bus.ras_miss,
                         m_ras.size(), m_miss);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_boot_step();
        test_stall();
        test_trap();
        test_ras();
        test_halt();
        test_wrap_async();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
